// File: rtl/vga_capture.sv
// vga_capture: locks onto an incoming VGA timing stream and emits one
// frame-buffer write per active pixel once a full frame has verified clean.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   HUNT   | waiting for the first line-0 start; timing is not checked
//   VERIFY | one frame under observation; any violation drops back to HUNT
//   LOCKED | timing trusted; active pixels are written to the frame buffer
//
// Pipeline: edge k samples the pins, edge k+1 updates the timing state and
// decides whether the sample is a pixel, edge k+2 presents the write.
module vga_capture #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  vgaRed,
  input  logic [2:0]  vgaGreen,
  input  logic [1:0]  vgaBlue,
  input  logic        Hsync,
  input  logic        Vsync,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [18:0] pix_addr,
  output logic [7:0]  pix_data,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err,
  output logic [7:0]  err_cnt
);

  // Counter widths leave headroom for one value past the total so the
  // counters can saturate there when the stream stops toggling.
  localparam int H_CW = $clog2(H_TOTAL + 2);
  localparam int V_CW = $clog2(V_TOTAL + 2);

  localparam logic [H_CW-1:0] H_TOT_C   = H_CW'(H_TOTAL);
  localparam logic [H_CW-1:0] H_FIRST_C = H_CW'(H_SYNC + H_BACK);
  localparam logic [H_CW-1:0] H_END_C   = H_CW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [V_CW-1:0] V_TOT_C   = V_CW'(V_TOTAL);
  localparam logic [V_CW-1:0] V_LAST_C  = V_CW'(V_TOTAL - 1);
  localparam logic [V_CW-1:0] V_FIRST_C = V_CW'(V_SYNC + V_BACK);
  localparam logic [V_CW-1:0] V_END_C   = V_CW'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Input sample stage
  logic       hs_q, hs_p_q, vs_q, vs_p_q, primed_q;
  logic [7:0] rgb_q;

  // Timing state
  state_e          state_q, state_d;
  logic [H_CW-1:0] h_cnt_q, h_cnt_d, h_inc;
  logic [V_CW-1:0] n_q, n_cnt_d, n_inc;
  logic            vs_pend_q, vs_pend_d;
  logic            locked_q, frame_start_q, frame_start_d, sync_err_q;
  logic [7:0]      err_cnt_q;

  // Pixel decision stage
  logic       we1_q, we1_d;
  logic [9:0] x1_q, x1_d;
  logic [8:0] y1_q, y1_d;
  logic [7:0] data1_q;

  // Output stage
  logic        pix_we_q, pix_we_d;
  logic [9:0]  pix_x_q;
  logic [8:0]  pix_y_q;
  logic [18:0] pix_addr_q;
  logic [7:0]  pix_data_q;

  logic hs_fall, vs_fall, line0, viol;
  logic line_early, line_late, vs_misplaced, frame_long;
  logic in_h, in_v;

  // Sample the pins. The first sample after reset seeds both history taps
  // so a low sync level at release is not mistaken for a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q     <= 1'b1;
      hs_p_q   <= 1'b1;
      vs_q     <= 1'b1;
      vs_p_q   <= 1'b1;
      primed_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hs_q     <= Hsync;
      vs_q     <= Vsync;
      hs_p_q   <= primed_q ? hs_q : Hsync;
      vs_p_q   <= primed_q ? vs_q : Vsync;
      primed_q <= 1'b1;
      rgb_q    <= {vgaRed, vgaGreen, vgaBlue};
    end
  end

  assign hs_fall = hs_p_q & ~hs_q;
  assign vs_fall = vs_p_q & ~vs_q;
  // A Vsync fall arms line 0; the arming Hsync fall may be the same sample.
  assign line0   = hs_fall & (vs_pend_q | vs_fall);
  assign h_inc   = h_cnt_q + 1'b1;
  assign n_inc   = n_q + 1'b1;

  // Line/column counters for the current sample, saturating at the totals.
  always_comb begin
    h_cnt_d = h_cnt_q;
    if (hs_fall) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != H_TOT_C) begin
      h_cnt_d = h_inc;
    end
    n_cnt_d = n_q;
    if (line0) begin
      n_cnt_d = '0;
    end else if (hs_fall && (n_q != V_TOT_C)) begin
      n_cnt_d = n_inc;
    end
    vs_pend_d = hs_fall ? 1'b0 : (vs_pend_q | vs_fall);
  end

  // Timing violations. The Vsync check uses the line number before this
  // sample's Hsync fall, so a Vsync fall coincident with the line-0 Hsync
  // fall belongs to the last line of the previous frame.
  always_comb begin
    line_early   = hs_fall & (h_inc != H_TOT_C);
    line_late    = ~hs_fall & (h_inc == H_TOT_C);
    vs_misplaced = vs_fall & (n_q != V_LAST_C);
    frame_long   = hs_fall & ~line0 & (n_inc == V_TOT_C);
    viol         = (state_q != HUNT) &
                   (line_early | line_late | vs_misplaced | frame_long);
  end

  // Next-state logic; a violation sends us to HUNT, but a line-0 start in
  // the same sample is still honoured and moves straight on to VERIFY.
  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    case (state_q)
      HUNT:    if (line0) state_d = VERIFY;
      VERIFY:  if (line0) state_d = LOCKED;
      LOCKED:  state_d = LOCKED;
      default: state_d = HUNT;
    endcase
    if (viol) begin
      state_d = line0 ? VERIFY : HUNT;
    end
    frame_start_d = line0 & (state_d == LOCKED);
  end

  // State, counters and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      h_cnt_q       <= '0;
      n_q           <= '0;
      vs_pend_q     <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      n_q           <= n_cnt_d;
      vs_pend_q     <= vs_pend_d;
      locked_q      <= (state_d == LOCKED);
      frame_start_q <= frame_start_d;
      sync_err_q    <= viol;
      if (viol && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  // Is the current sample an active pixel of a locked frame?
  always_comb begin
    in_h  = (h_cnt_d >= H_FIRST_C) && (h_cnt_d < H_END_C);
    in_v  = (n_cnt_d >= V_FIRST_C) && (n_cnt_d < V_END_C);
    we1_d = (state_q == LOCKED) & ~viol & in_h & in_v;
    x1_d  = 10'(h_cnt_d - H_FIRST_C);
    y1_d  = 9'(n_cnt_d - V_FIRST_C);
  end

  // Pixel decision register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we1_q   <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      data1_q <= '0;
    end else begin
      we1_q   <= we1_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      data1_q <= rgb_q;
    end
  end

  // A violation also cancels the write already in flight.
  assign pix_we_d = we1_q & ~viol;

  // Output register: all pixel fields move together and hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_we_q   <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
    end else begin
      pix_we_q <= pix_we_d;
      if (pix_we_d) begin
        pix_x_q    <= x1_q;
        pix_y_q    <= y1_q;
        pix_addr_q <= 19'(y1_q) * 19'(H_ACTIVE) + 19'(x1_q);
        pix_data_q <= data1_q;
      end
    end
  end

  assign pix_we      = pix_we_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_addr    = pix_addr_q;
  assign pix_data    = pix_data_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture using a shrunken timing so whole frames fit in a
// short run. The driver pushes the expected write for every pixel it sends
// while capture is expected; the monitor pops on each pix_we.
module tb_vga_capture;

  localparam int HT = 20, HS = 3, HB = 2, HA = 10;
  localparam int VT = 12, VS = 2, VB = 2, VA = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vgaRed, vgaGreen;
  logic [1:0]  vgaBlue;
  logic        Hsync, Vsync;
  logic        pix_we;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [18:0] pix_addr;
  logic [7:0]  pix_data;
  logic        locked, frame_start, sync_err;
  logic [7:0]  err_cnt;

  vga_capture #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst(rst),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .Hsync(Hsync), .Vsync(Vsync),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .locked(locked), .frame_start(frame_start),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] addr;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  d;
  } pix_t;

  pix_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   serr_seen = 0;
  int   fs_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({pix_we, pix_x, pix_y, pix_addr, pix_data,
                   locked, frame_start, sync_err, err_cnt}), 64'd0);
  endtask

  // Monitor: compare every write against the scoreboard, count pulses.
  always @(negedge clk) begin
    pix_t e;
    if (sync_err) serr_seen++;
    if (frame_start) fs_seen++;
    if (pix_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_write: addr %0d x %0d y %0d data 0x%0h, no write expected at %0t",
                 pix_addr, pix_x, pix_y, pix_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", 64'({pix_addr, pix_x, pix_y, pix_data}), 64'(e));
      end
    end
  end

  task automatic drive(input logic h, input logic v, input logic [7:0] rgb);
    @(negedge clk);
    Hsync = h;
    Vsync = v;
    {vgaRed, vgaGreen, vgaBlue} = rgb;
  endtask

  // One frame: lines start with an Hsync fall at h=0; Vsync low for the
  // first VS lines. Lines up to cap_last are expected to be captured.
  task automatic drive_frame(input int f, input int nlines, input int long_line,
                             input int cap_last, input bit vs_on, input int rst_line);
    for (int ln = 0; ln < nlines; ln++) begin
      int len;
      len = (ln == long_line) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        logic [7:0] rgb;
        pix_t       e;
        rgb = 8'(f * 29 + ln * 13 + h * 7);
        drive(h >= HS, !(vs_on && ln < VS), rgb);
        if (ln <= cap_last && ln >= VS + VB && ln < VS + VB + VA &&
            h >= HS + HB && h < HS + HB + HA) begin
          e.addr = 19'((ln - VS - VB) * HA + (h - HS - HB));
          e.x    = 10'(h - HS - HB);
          e.y    = 9'(ln - VS - VB);
          e.d    = rgb;
          exp_q.push_back(e);
        end
        if (ln == rst_line && h == 8) begin
          #2 rst = 1'b1;
          #1 chk_zero("mid_frame_reset_outputs");
        end
        if (ln == rst_line && h == 12) rst = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    Hsync = 1'b1;
    Vsync = 1'b1;
    {vgaRed, vgaGreen, vgaBlue} = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    repeat (5) drive(1'b1, 1'b1, 8'h00);

    // f0 verifies, f1 locks
    drive_frame(0, VT, -1, -1, 1'b1, -1);
    chk("locked_after_verify_frame", 64'(locked), 64'd0);
    chk("no_frame_start_in_verify", 64'(fs_seen), 64'd0);
    drive_frame(1, VT, -1, VT, 1'b1, -1);
    drive_frame(2, VT, -1, VT, 1'b1, -1);
    chk("locked_nominal", 64'(locked), 64'd1);
    chk("frame_starts_nominal", 64'(fs_seen), 64'd2);
    chk("no_sync_err_nominal", 64'(serr_seen), 64'd0);

    // long line 5 while locked
    drive_frame(3, VT, 5, 5, 1'b1, -1);
    chk("locked_after_long_line", 64'(locked), 64'd0);
    chk("sync_err_long_line", 64'(serr_seen), 64'd1);
    chk("err_cnt_long_line", 64'(err_cnt), 64'd1);
    drive_frame(4, VT, -1, -1, 1'b1, -1);
    chk("verify_after_long_line", 64'(locked), 64'd0);
    drive_frame(5, VT, -1, VT, 1'b1, -1);
    chk("relocked", 64'(locked), 64'd1);
    chk("frame_starts_relock", 64'(fs_seen), 64'd4);

    // short frame while locked; error at next Vsync fall
    drive_frame(6, VT - 1, -1, VT, 1'b1, -1);
    chk("locked_before_short_frame_end", 64'(locked), 64'd1);
    drive_frame(7, VT, -1, -1, 1'b1, -1);
    chk("locked_after_short_frame", 64'(locked), 64'd0);
    chk("sync_err_short_frame", 64'(serr_seen), 64'd2);
    chk("err_cnt_short_frame", 64'(err_cnt), 64'd2);
    chk("frame_starts_short_frame", 64'(fs_seen), 64'd5);
    drive_frame(8, VT, -1, VT, 1'b1, -1);
    chk("locked_after_recovery", 64'(locked), 64'd1);

    // mid-frame reset in a locked frame
    drive_frame(9, VT, -1, VT, 1'b1, 10);
    chk("locked_after_mid_reset", 64'(locked), 64'd0);
    chk("err_cnt_after_mid_reset", 64'(err_cnt), 64'd0);
    drive_frame(10, VT, -1, -1, 1'b1, -1);
    drive_frame(11, VT, -1, VT, 1'b1, -1);
    chk("locked_after_reset_recovery", 64'(locked), 64'd1);
    chk("no_sync_err_from_reset", 64'(serr_seen), 64'd2);
    chk("frame_starts_after_reset", 64'(fs_seen), 64'd8);

    // reset before the stream stops, then Vsync held high
    #2 rst = 1'b1;
    #1 chk_zero("second_reset_outputs");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 8'h00);
    drive_frame(12, VT, -1, -1, 1'b0, -1);
    drive_frame(13, VT, -1, -1, 1'b0, -1);
    chk("hunt_no_vsync_locked", 64'(locked), 64'd0);
    chk("hunt_no_vsync_sync_err", 64'(serr_seen), 64'd2);
    chk("hunt_no_vsync_frame_start", 64'(fs_seen), 64'd8);

    // forced violations: line-0 start then an early Hsync fall
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 8'h00);
      if (i == 253) begin
        repeat (3) drive(1'b1, 1'b1, 8'h00);
        chk("err_cnt_254", 64'(err_cnt), 64'd254);
      end
      if (i == 254) begin
        repeat (3) drive(1'b1, 1'b1, 8'h00);
        chk("err_cnt_255", 64'(err_cnt), 64'd255);
      end
    end
    repeat (3) drive(1'b1, 1'b1, 8'h00);
    chk("err_cnt_saturated", 64'(err_cnt), 64'd255);
    chk("sync_err_pulses_forced", 64'(serr_seen), 64'd302);
    chk("locked_after_forced", 64'(locked), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
